video_tpg: RTL and testbench

VIDEO_TPG -- requirements
Module: video_tpg

---
 rtl/video_tpg_if.sv | 19 +
 rtl/video_tpg.sv | 185 ++++++++++++++++++
 tb/tb_video_tpg.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_tpg_if.sv
// Video output bus of the test pattern generator.
//   hs_q   horizontal sync
//   vs_q   vertical sync
//   vld_q  data valid (active picture area)
//   sof_q  one-cycle start-of-frame pulse
//   rgb    pixel {R,G,B}, R in the MSBs
// Modports: master drives the bus (the generator), slave observes it.
interface video_tpg_if #(
    parameter int PW = 8
);
    logic            hs_q;
    logic            vs_q;
    logic            vld_q;
    logic            sof_q;
    logic [3*PW-1:0] rgb;

    modport master (output hs_q, vs_q, vld_q, sof_q, rgb);
    modport slave  (input  hs_q, vs_q, vld_q, sof_q, rgb);
endinterface

// File: rtl/video_tpg.sv
// Video timing and test pattern generator.
//
// A pixel counter x (0..tH_END) and line counter y (0..tV_END) advance while
// en is high. From the current (x,y) the block derives sync, data-valid and a
// pixel colour, and registers them onto the video bus one clock later.
// Patterns: 0 running pixel counter, 1 eight colour bars, 2 x/y ramp,
// 3 solid colour. The pattern is latched at the first pixel of each frame.
//
// Optional build macro VIDEO_TPG_MOTION_EN: adds a frame counter that scrolls
// the colour bars and shifts the red ramp every frame.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   en           advance timing when high, hold everything when low
//   mode         pattern select (sampled at x=0,y=0)
//   solid_rgb    colour for the solid pattern
//   tHS_*/tHACT_*/tH_END  horizontal timing, pixel units
//   tVS_*/tVACT_*/tV_END  vertical timing, line units
//   vid          registered video bus (hs_q, vs_q, vld_q, sof_q, rgb)
module video_tpg #(
    parameter int PW        = 8,
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int BAR_SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [3*PW-1:0]   solid_rgb,
    input  logic [H_BITS-1:0] tHS_START,
    input  logic [H_BITS-1:0] tHS_END,
    input  logic [H_BITS-1:0] tHACT_START,
    input  logic [H_BITS-1:0] tHACT_END,
    input  logic [H_BITS-1:0] tH_END,
    input  logic [V_BITS-1:0] tVS_START,
    input  logic [V_BITS-1:0] tVS_END,
    input  logic [V_BITS-1:0] tVACT_START,
    input  logic [V_BITS-1:0] tVACT_END,
    input  logic [V_BITS-1:0] tV_END,
    video_tpg_if.master       vid
);

    typedef enum logic [1:0] {
        PAT_COUNT = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    // Raster position and per-frame state
    logic [H_BITS-1:0] xPos;
    logic [V_BITS-1:0] yPos;
    pattern_e          modeReg;
    logic [PW-1:0]     pixCnt;

    // Combinational view of the current pixel
    logic              frameStart;
    logic              lineEnd;
    logic              frameEnd;
    pattern_e          activeMode;
    logic              hsNext;
    logic              vsNext;
    logic              vldNext;
    logic [PW-1:0]     curCnt;
    logic [H_BITS-1:0] barOffset;
    logic [H_BITS-1:0] barRaw;
    logic [2:0]        barIdx;
    logic [2:0]        barSel;
    logic [2:0]        barBits;
    logic [PW-1:0]     rampR;
    logic [PW-1:0]     rampG;
    logic [PW-1:0]     rampB;
    logic [3*PW-1:0]   rgbNext;

    assign frameStart = (xPos == '0) && (yPos == '0);
    // >= rather than == so a shrinking END still wraps the counter
    assign lineEnd    = (xPos >= tH_END);
    assign frameEnd   = lineEnd && (yPos >= tV_END);

    // The new pattern applies from the very first pixel of the frame it is
    // sampled in, so the whole frame uses one pattern.
    assign activeMode = frameStart ? pattern_e'(mode) : modeReg;

    // Half-open windows: START >= END gives an empty window.
    assign hsNext  = (xPos >= tHS_START) && (xPos < tHS_END);
    assign vsNext  = (yPos >= tVS_START) && (yPos < tVS_END);
    assign vldNext = (xPos >= tHACT_START) && (xPos < tHACT_END) &&
                     (yPos >= tVACT_START) && (yPos < tVACT_END);

    // Pixel counter restarts at every frame; the pixel shows the count of
    // valid pixels that preceded it in the frame.
    assign curCnt = frameStart ? '0 : pixCnt;

    // Bar index saturates at the last bar instead of wrapping.
    assign barOffset = xPos - tHACT_START;
    assign barRaw    = barOffset >> BAR_SHIFT;
    assign barIdx    = (barRaw > H_BITS'(7)) ? 3'd7 : barRaw[2:0];

    assign rampG = PW'(yPos);
    assign rampB = PW'(xPos) + PW'(yPos);

`ifdef VIDEO_TPG_MOTION_EN
    logic [V_BITS-1:0] frameCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frameCnt <= '0;
        end else if (en && frameEnd) begin
            frameCnt <= frameCnt + V_BITS'(1);
        end
    end

    assign barSel = barIdx + frameCnt[2:0];
    assign rampR  = PW'(xPos) + PW'(frameCnt);
`else
    assign barSel = barIdx;
    assign rampR  = PW'(xPos);
`endif

    // {R,G,B} on/off for white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        barBits = 3'b000;
        case (barSel)
            3'd0:    barBits = 3'b111;
            3'd1:    barBits = 3'b110;
            3'd2:    barBits = 3'b011;
            3'd3:    barBits = 3'b010;
            3'd4:    barBits = 3'b101;
            3'd5:    barBits = 3'b100;
            3'd6:    barBits = 3'b001;
            default: barBits = 3'b000;
        endcase
    end

    always_comb begin
        rgbNext = '0;
        if (vldNext) begin
            case (activeMode)
                PAT_COUNT: rgbNext = {curCnt, curCnt, curCnt};
                PAT_BARS:  rgbNext = {{PW{barBits[2]}}, {PW{barBits[1]}}, {PW{barBits[0]}}};
                PAT_RAMP:  rgbNext = {rampR, rampG, rampB};
                PAT_SOLID: rgbNext = solid_rgb;
                default:   rgbNext = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            xPos      <= '0;
            yPos      <= '0;
            modeReg   <= PAT_COUNT;
            pixCnt    <= '0;
            vid.hs_q  <= 1'b0;
            vid.vs_q  <= 1'b0;
            vid.vld_q <= 1'b0;
            vid.sof_q <= 1'b0;
            vid.rgb   <= '0;
        end else if (en) begin
            if (lineEnd) begin
                xPos <= '0;
                yPos <= frameEnd ? '0 : yPos + V_BITS'(1);
            end else begin
                xPos <= xPos + H_BITS'(1);
            end
            modeReg   <= activeMode;
            pixCnt    <= curCnt + PW'(vldNext);
            vid.hs_q  <= hsNext;
            vid.vs_q  <= vsNext;
            vid.vld_q <= vldNext;
            vid.sof_q <= frameStart;
            vid.rgb   <= rgbNext;
        end else begin
            // Stalled: everything holds except the frame pulse.
            vid.sof_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_tpg.sv
// Self-checking bench for video_tpg. A behavioural raster model (integer
// x/y position, valid-pixel tally and named colour table) predicts every
// registered output after each clock edge.
module tb_video_tpg;

    localparam int PW        = 8;
    localparam int H_BITS    = 12;
    localparam int V_BITS    = 12;
    localparam int BAR_SHIFT = 1;

`ifdef VIDEO_TPG_MOTION_EN
    localparam bit MOTION_ON = 1'b1;
`else
    localparam bit MOTION_ON = 1'b0;
`endif

    localparam logic [23:0] BAR_COLOUR [8] = '{
        24'hFFFFFF,  // white
        24'hFFFF00,  // yellow
        24'h00FFFF,  // cyan
        24'h00FF00,  // green
        24'hFF00FF,  // magenta
        24'hFF0000,  // red
        24'h0000FF,  // blue
        24'h000000   // black
    };

    logic              clk;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [3*PW-1:0]   solid_rgb;
    logic [H_BITS-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;

    video_tpg_if #(.PW(PW)) vif ();

    video_tpg #(
        .PW(PW), .H_BITS(H_BITS), .V_BITS(V_BITS), .BAR_SHIFT(BAR_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .tHS_START(tHS_START), .tHS_END(tHS_END),
        .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END),
        .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
        .vid(vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          mx, my, mcnt, mfc;
    logic [1:0]  mmode;
    logic        expHs, expVs, expVld, expSof;
    logic [23:0] expRgb;

    int checks;
    int errors;

    // Directed-scenario bookkeeping
    int          hsCount, vsCount, sofCount, lastSof, sofGap;
    logic [23:0] lastVldF1, firstVldF2;
    bit          gotFirstF2;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(int v, int lo, int hi);
        return (v >= lo) && (v < hi);
    endfunction

    // One clock edge of the raster, computed from the pattern rules.
    task automatic model_edge();
        int bar;
        int motion;
        if (rst) begin
            mx = 0; my = 0; mcnt = 0; mfc = 0; mmode = 2'd0;
            expHs = 1'b0; expVs = 1'b0; expVld = 1'b0; expSof = 1'b0;
            expRgb = '0;
        end else if (en) begin
            motion = MOTION_ON ? mfc : 0;
            expSof = (mx == 0) && (my == 0);
            if (expSof) begin
                mmode = mode;
                mcnt  = 0;
            end
            expHs  = in_range(mx, int'(tHS_START), int'(tHS_END));
            expVs  = in_range(my, int'(tVS_START), int'(tVS_END));
            expVld = in_range(mx, int'(tHACT_START), int'(tHACT_END)) &&
                     in_range(my, int'(tVACT_START), int'(tVACT_END));
            expRgb = '0;
            if (expVld) begin
                case (mmode)
                    2'd0: expRgb = {3{8'(mcnt)}};
                    2'd1: begin
                        bar = (mx - int'(tHACT_START)) / (1 << BAR_SHIFT);
                        if (bar > 7) bar = 7;
                        expRgb = BAR_COLOUR[(bar + motion) % 8];
                    end
                    2'd2: expRgb = {8'(mx + motion), 8'(my), 8'(mx + my)};
                    default: expRgb = solid_rgb;
                endcase
                mcnt++;
            end
            if (mx >= int'(tH_END)) begin
                mx = 0;
                if (my >= int'(tV_END)) begin
                    my = 0;
                    mfc++;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end else begin
            expSof = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("hs_q",  vif.hs_q,  expHs);
        check("vs_q",  vif.vs_q,  expVs);
        check("vld_q", vif.vld_q, expVld);
        check("sof_q", vif.sof_q, expSof);
        check("rgb",   vif.rgb,   expRgb);
    endtask

    // Clock edge, model update, then sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_timing(int hE, int hsS, int hsE, int haS, int haE,
                              int vE, int vsS, int vsE, int vaS, int vaE);
        tH_END      = H_BITS'(hE);
        tHS_START   = H_BITS'(hsS);
        tHS_END     = H_BITS'(hsE);
        tHACT_START = H_BITS'(haS);
        tHACT_END   = H_BITS'(haE);
        tV_END      = V_BITS'(vE);
        tVS_START   = V_BITS'(vsS);
        tVS_END     = V_BITS'(vsE);
        tVACT_START = V_BITS'(vaS);
        tVACT_END   = V_BITS'(vaE);
    endtask

    // Timing is only changed while reset is held.
    task automatic restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Advance until the model reaches (x,y) as the next pixel, bounded.
    task automatic wait_pos(int x, int y, int budget);
        int n;
        n = 0;
        while (!((mx == x) && (my == y)) && (n < budget)) begin
            tick();
            n++;
        end
        check("wait_pos_reached", 32'((mx == x) && (my == y)), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mx = 0; my = 0; mcnt = 0; mfc = 0; mmode = 2'd0;
        expHs = 1'b0; expVs = 1'b0; expVld = 1'b0; expSof = 1'b0; expRgb = '0;

        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'd0;
        solid_rgb = 24'h123456;
        set_timing(15, 13, 15, 2, 12, 7, 6, 8, 1, 5);

        // Reset state, with and without en
        run(2);
        en = 1'b1;
        run(1);
        rst = 1'b0;

        // Counter pattern over two frames: sync counts, frame period, count span
        hsCount = 0; vsCount = 0; sofCount = 0; lastSof = -1; sofGap = 0;
        lastVldF1 = '0; firstVldF2 = 24'hFFFFFF; gotFirstF2 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (vif.hs_q === 1'b1) hsCount++;
            if (vif.vs_q === 1'b1) vsCount++;
            if (vif.sof_q === 1'b1) begin
                sofCount++;
                if (lastSof >= 0) sofGap = i - lastSof;
                lastSof = i;
            end
            if (vif.vld_q === 1'b1) begin
                if (sofCount == 1) lastVldF1 = vif.rgb;
                if ((sofCount == 2) && !gotFirstF2) begin
                    firstVldF2 = vif.rgb;
                    gotFirstF2 = 1'b1;
                end
            end
        end
        check("hs_cycles_2_frames",  hsCount,  32);
        check("vs_cycles_2_frames",  vsCount,  64);
        check("sof_count_2_frames",  sofCount, 2);
        check("sof_period",          sofGap,   128);
        check("cnt_last_vld",        lastVldF1, 24'h272727);
        check("cnt_first_vld_next",  firstVldF2, 24'h000000);

        // Solid colour, switched to counter mid-frame
        mode = 2'd3;
        solid_rgb = 24'hA5C33C;
        wait_pos(0, 0, 200);
        run(1);
        wait_pos(0, 3, 200);
        mode = 2'd0;
        run(200);

        // Stall mid-line for 5 cycles
        wait_pos(8, 2, 200);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(40);

        // Reset mid-frame
        wait_pos(7, 4, 200);
        rst = 1'b1;
        tick();
        check("rst_rgb_zero", vif.rgb, 24'h0);
        check("rst_vld_zero", vif.vld_q, 1'b0);
        rst = 1'b0;
        tick();
        check("sof_after_release", vif.sof_q, 1'b1);
        run(60);

        // Colour bars, width 2, with saturation beyond the eighth bar
        set_timing(23, 30, 31, 0, 22, 2, 1, 2, 0, 2);
        mode = 2'd1;
        restart();
        run(24 * 3 * 3);

        // x/y ramp
        set_timing(40, 3, 9, 5, 38, 9, 0, 2, 1, 9);
        mode = 2'd2;
        restart();
        run(41 * 10 * 2);

        // Zero-width line: y advances every cycle
        set_timing(0, 0, 1, 0, 1, 9, 2, 4, 2, 7);
        restart();
        run(40);

        // Single-line frame with the counter pattern
        set_timing(20, 3, 5, 1, 15, 0, 0, 1, 0, 1);
        mode = 2'd0;
        restart();
        run(70);

        // Randomized timing, patterns, stalls and resets
        for (int t = 0; t < 12; t++) begin
            int hE, vE;
            hE = int'($urandom_range(0, 28));
            vE = int'($urandom_range(0, 10));
            set_timing(hE,
                       int'($urandom_range(0, hE + 1)), int'($urandom_range(0, hE + 2)),
                       int'($urandom_range(0, hE)),     int'($urandom_range(0, hE + 2)),
                       vE,
                       int'($urandom_range(0, vE + 1)), int'($urandom_range(0, vE + 2)),
                       int'($urandom_range(0, vE)),     int'($urandom_range(0, vE + 2)));
            mode = 2'($urandom_range(0, 3));
            restart();
            for (int c = 0; c < 300; c++) begin
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) solid_rgb = 24'($urandom);
                rst = ($urandom_range(0, 399) == 0);
                tick();
            end
            rst = 1'b0;
            en  = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
